// File: rtl/sfsm_flash_rd_if.sv
// Port bundle between the sfsm configuration loader, the read sequencer and the SPI flash pins.
// The slave modport is the sequencer's view; the master modport is the view from outside the sequencer.
interface sfsm_flash_rd_if #(
    parameter int ADDR_W = 16
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        len;
    logic              abort;
    logic              busy;
    logic              dvalid;
    logic [7:0]        ddata;
    logic              dlast;
    logic              cs;
    logic              dout;
    logic              din;

    modport master (
        output req, addr, len, abort, din,
        input  busy, dvalid, ddata, dlast, cs, dout
    );

    modport slave (
        input  req, addr, len, abort, din,
        output busy, dvalid, ddata, dlast, cs, dout
    );
endinterface

// File: rtl/sfsm_flash_rd.sv
// Serial-flash READ (0x03) sequencer: sends the command and a 24-bit address, then collects
// a 1..8 byte burst MSB first and hands each byte to the sfsm configuration loader.
module sfsm_flash_rd #(
    parameter int ADDR_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    sfsm_flash_rd_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;

    logic [ADDR_W-1:0] addr_s;
    logic [23:0]       addr24_s;
    logic [31:0]       hdr_sr_r;
    logic [4:0]        bit_cnt_r;
    logic [2:0]        byte_cnt_r;
    logic [2:0]        len_r;
    logic [6:0]        rx_sr_r;
    logic [7:0]        byte_s;
    logic              hdr_done_s;
    logic              byte_done_s;
    logic              last_s;

    logic              cs_r;
    logic              busy_r;
    logic              dvalid_r;
    logic              dlast_r;
    logic [7:0]        ddata_r;
    logic              cs_nxt_s;
    logic              busy_nxt_s;
    logic              dvalid_nxt_s;
    logic              dlast_nxt_s;
    logic [7:0]        ddata_nxt_s;

    // Command byte followed by the zero-extended start address, MSB first on the wire.
    function automatic logic [31:0] read_frame(input logic [23:0] a);
        return {8'h03, a};
    endfunction

    assign addr_s      = bus.addr;
    assign addr24_s    = 24'(addr_s);
    assign byte_s      = {rx_sr_r, bus.din};
    assign hdr_done_s  = (bit_cnt_r == 5'd31);
    assign byte_done_s = (bit_cnt_r[2:0] == 3'd7);
    assign last_s      = byte_done_s && (byte_cnt_r == len_r);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a final sample coinciding with abort still completes normally.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req) begin
                    state_nxt_s = ST_HDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (bus.abort) begin
                    state_nxt_s = ST_GAP;
                end else if (hdr_done_s) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_HDR;
                end
            end
            ST_DATA: begin
                if (last_s || bus.abort) begin
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_GAP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Header shifter, bit/byte counters and receive shifter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr_sr_r   <= 32'd0;
            bit_cnt_r  <= 5'd0;
            byte_cnt_r <= 3'd0;
            len_r      <= 3'd0;
            rx_sr_r    <= 7'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    bit_cnt_r  <= 5'd0;
                    byte_cnt_r <= 3'd0;
                    rx_sr_r    <= 7'd0;
                    if (bus.req) begin
                        hdr_sr_r <= read_frame(addr24_s);
                        len_r    <= bus.len;
                    end else begin
                        hdr_sr_r <= 32'd0;
                        len_r    <= len_r;
                    end
                end
                ST_HDR: begin
                    // Zeros shift in behind the frame, so dout idles low once the header is out.
                    if (bus.abort) begin
                        hdr_sr_r  <= 32'd0;
                        bit_cnt_r <= 5'd0;
                    end else begin
                        hdr_sr_r  <= {hdr_sr_r[30:0], 1'b0};
                        bit_cnt_r <= hdr_done_s ? 5'd0 : (bit_cnt_r + 5'd1);
                    end
                end
                ST_DATA: begin
                    rx_sr_r   <= byte_s[6:0];
                    bit_cnt_r <= bit_cnt_r + 5'd1;
                    if (byte_done_s) begin
                        byte_cnt_r <= byte_cnt_r + 3'd1;
                    end else begin
                        byte_cnt_r <= byte_cnt_r;
                    end
                end
                default: begin
                    hdr_sr_r   <= 32'd0;
                    bit_cnt_r  <= 5'd0;
                    byte_cnt_r <= 3'd0;
                    rx_sr_r    <= 7'd0;
                end
            endcase
        end
    end

    // Output decode: next values of the registered pins and the consumer strobe.
    always_comb begin
        cs_nxt_s     = 1'b1;
        busy_nxt_s   = 1'b0;
        dvalid_nxt_s = 1'b0;
        dlast_nxt_s  = 1'b0;
        ddata_nxt_s  = ddata_r;
        if ((state_nxt_s == ST_HDR) || (state_nxt_s == ST_DATA)) begin
            cs_nxt_s = 1'b0;
        end else begin
            cs_nxt_s = 1'b1;
        end
        if (state_nxt_s != ST_IDLE) begin
            busy_nxt_s = 1'b1;
        end else begin
            busy_nxt_s = 1'b0;
        end
        // An abort drops a byte completing on the same edge unless it is the last one.
        if ((state_r == ST_DATA) && byte_done_s && (last_s || !bus.abort)) begin
            dvalid_nxt_s = 1'b1;
            dlast_nxt_s  = last_s;
            ddata_nxt_s  = byte_s;
        end else begin
            dvalid_nxt_s = 1'b0;
            dlast_nxt_s  = 1'b0;
            ddata_nxt_s  = ddata_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_r     <= 1'b1;
            busy_r   <= 1'b0;
            dvalid_r <= 1'b0;
            dlast_r  <= 1'b0;
            ddata_r  <= 8'd0;
        end else begin
            cs_r     <= cs_nxt_s;
            busy_r   <= busy_nxt_s;
            dvalid_r <= dvalid_nxt_s;
            dlast_r  <= dlast_nxt_s;
            ddata_r  <= ddata_nxt_s;
        end
    end

    assign bus.cs     = cs_r;
    assign bus.dout   = hdr_sr_r[31];
    assign bus.busy   = busy_r;
    assign bus.dvalid = dvalid_r;
    assign bus.dlast  = dlast_r;
    assign bus.ddata  = ddata_r;

endmodule

// File: tb/tb_sfsm_flash_rd.sv
// Self-checking bench for sfsm_flash_rd: cycle-indexed reference of the SPI READ transaction.
module tb_sfsm_flash_rd;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_ddata;
    logic [7:0] fdata [8];

    always #5 clk = ~clk;

    sfsm_flash_rd_if #(.ADDR_W(16)) bus ();
    sfsm_flash_rd_if #(.ADDR_W(8))  bus8 ();

    sfsm_flash_rd #(.ADDR_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    sfsm_flash_rd #(.ADDR_W(8))  dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

    task automatic test_reset();
        rst = 1'b0;
        bus.req = 1'b0;  bus.addr = 16'd0; bus.len = 3'd0; bus.abort = 1'b0; bus.din = 1'b0;
        bus8.req = 1'b0; bus8.addr = 8'd0; bus8.len = 3'd0; bus8.abort = 1'b0; bus8.din = 1'b0;
        exp_ddata = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.cs, bus.dout, bus.busy, bus.dvalid, bus.dlast, bus.ddata} !== {4'b1000, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_state got cs%b dout%b busy%b dv%b dl%b dd%h exp 1 0 0 0 0 00",
                     bus.cs, bus.dout, bus.busy, bus.dvalid, bus.dlast, bus.ddata);
        end
        checks++;
        if ({bus8.cs, bus8.busy, bus8.dvalid} !== 3'b100) begin
            errors++;
            $display("FAIL reset_state8 got cs%b busy%b dv%b exp 1 0 0", bus8.cs, bus8.busy, bus8.dvalid);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One transaction on the 16-bit instance; abort_k/breq_k/rst_k < 0 disable those events.
    task automatic run_txn(input logic [15:0] a, input logic [2:0] l,
                           input int abort_k, input int breq_k, input int rst_k);
        logic [31:0] frame;
        int   endk, gapk, jj, nb, bi;
        logic exp_cs, exp_busy, exp_dv, exp_dl;
        bit   stop;
        frame = {8'h03, 8'h00, a};
        endk  = 32 + 8 * (int'(l) + 1);
        gapk  = (abort_k >= 0) ? abort_k + 1 : endk;
        jj    = (abort_k >= 0) ? abort_k : 1000000;
        bus.req = 1'b1; bus.addr = a; bus.len = l;
        @(posedge clk);
        #1;
        bus.req = 1'b0; bus.abort = 1'b0;
        bus.addr = 16'($urandom); bus.len = 3'($urandom);
        stop = 1'b0;
        for (int k = 0; (k <= gapk + 1) && !stop; k++) begin
            exp_cs   = (k < gapk) ? 1'b0 : 1'b1;
            exp_busy = (k <= gapk) ? 1'b1 : 1'b0;
            exp_dv   = 1'b0;
            exp_dl   = 1'b0;
            if ((k >= 40) && ((k - 40) % 8 == 0)) begin
                nb = (k - 40) / 8;
                if ((nb <= int'(l)) && ((39 + 8 * nb < jj) || ((nb == int'(l)) && (39 + 8 * nb == jj)))) begin
                    exp_dv    = 1'b1;
                    exp_dl    = (nb == int'(l));
                    exp_ddata = fdata[nb];
                end
            end
            checks++;
            if (bus.cs !== exp_cs) begin
                errors++;
                $display("FAIL cs C%0d got %b exp %b", k, bus.cs, exp_cs);
            end
            checks++;
            if (bus.busy !== exp_busy) begin
                errors++;
                $display("FAIL busy C%0d got %b exp %b", k, bus.busy, exp_busy);
            end
            checks++;
            if ({bus.dvalid, bus.dlast} !== {exp_dv, exp_dl}) begin
                errors++;
                $display("FAIL dvalid_dlast C%0d got %b%b exp %b%b", k, bus.dvalid, bus.dlast, exp_dv, exp_dl);
            end
            checks++;
            if (bus.ddata !== exp_ddata) begin
                errors++;
                $display("FAIL ddata C%0d got %h exp %h", k, bus.ddata, exp_ddata);
            end
            if (k < gapk) begin
                bi = (k < 32) ? 31 - k : 0;
                checks++;
                if (bus.dout !== ((k < 32) ? frame[bi] : 1'b0)) begin
                    errors++;
                    $display("FAIL dout C%0d got %b exp %b", k, bus.dout, (k < 32) ? frame[bi] : 1'b0);
                end
            end
            // Flash model: the bit sampled at the edge ending Ck.
            if ((k >= 32) && (k < endk)) begin
                nb = (k - 32) / 8;
                bi = 7 - ((k - 32) % 8);
                bus.din = fdata[nb][bi];
            end else begin
                bus.din = 1'($urandom);
            end
            // Abort in GAP/IDLE must be ignored.
            bus.abort = (k == abort_k) || (k >= gapk);
            if (k == breq_k) begin
                bus.req = 1'b1; bus.addr = ~a;
            end else begin
                bus.req = 1'b0;
            end
            if (k == rst_k) begin
                #1 rst = 1'b0;
                #1;
                exp_ddata = 8'd0;
                checks++;
                if ({bus.cs, bus.dout, bus.busy, bus.dvalid, bus.dlast, bus.ddata} !== {4'b1000, 1'b0, 8'h00}) begin
                    errors++;
                    $display("FAIL async_reset got cs%b dout%b busy%b dv%b dl%b dd%h exp 1 0 0 0 0 00",
                             bus.cs, bus.dout, bus.busy, bus.dvalid, bus.dlast, bus.ddata);
                end
                bus.abort = 1'b0; bus.req = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b1;
                @(posedge clk);
                #1;
                stop = 1'b1;
            end else if (k < gapk + 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_single();
        fdata[0] = 8'hA5;
        run_txn(16'h1234, 3'd0, -1, -1, -1);
    endtask

    task automatic test_max_burst();
        for (int i = 0; i < 8; i++) fdata[i] = 8'(i);
        run_txn(16'hBEEF, 3'd7, -1, -1, -1);
    endtask

    task automatic test_busy_req();
        fdata[0] = 8'h3C;
        run_txn(16'h1234, 3'd0, -1, 10, -1);
        fdata[0] = 8'hC3;
        run_txn(16'h4321, 3'd0, -1, -1, -1);
        bus.abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({bus.cs, bus.busy, bus.dvalid} !== 3'b100) begin
                errors++;
                $display("FAIL no_queued_req got cs%b busy%b dv%b exp 1 0 0", bus.cs, bus.busy, bus.dvalid);
            end
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 8; i++) fdata[i] = 8'($urandom);
        run_txn(16'h0456, 3'd3, 45, -1, -1);
        run_txn(16'h0789, 3'd2, 5, -1, -1);
        run_txn(16'h0ABC, 3'd1, 39, -1, -1);
        run_txn(16'h0DEF, 3'd1, 47, -1, -1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) fdata[i] = 8'($urandom);
        run_txn(16'h5A5A, 3'd2, -1, -1, 35);
        run_txn(16'h0F0F, 3'd1, -1, -1, -1);
    endtask

    task automatic test_addr_ext();
        logic [31:0] frame8;
        frame8 = 32'h030000FF;
        bus.abort = 1'b0;
        bus8.req = 1'b1; bus8.addr = 8'hFF; bus8.len = 3'd0; bus8.din = 1'b1;
        @(posedge clk);
        #1;
        bus8.req = 1'b0; bus8.addr = 8'h00;
        for (int k = 0; k <= 41; k++) begin
            if (k < 32) begin
                checks++;
                if (bus8.dout !== frame8[31 - k]) begin
                    errors++;
                    $display("FAIL addr_ext_dout C%0d got %b exp %b", k, bus8.dout, frame8[31 - k]);
                end
            end
            checks++;
            if (bus8.cs !== ((k < 40) ? 1'b0 : 1'b1)) begin
                errors++;
                $display("FAIL addr_ext_cs C%0d got %b exp %b", k, bus8.cs, (k < 40) ? 1'b0 : 1'b1);
            end
            if (k == 40) begin
                checks++;
                if ({bus8.dvalid, bus8.dlast, bus8.ddata} !== {2'b11, 8'hFF}) begin
                    errors++;
                    $display("FAIL addr_ext_data got dv%b dl%b dd%h exp 1 1 ff", bus8.dvalid, bus8.dlast, bus8.ddata);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [2:0]  l;
        int endk, ak, gk, bk;
        for (int t = 0; t < 10; t++) begin
            a = 16'($urandom);
            l = 3'($urandom);
            for (int i = 0; i < 8; i++) fdata[i] = 8'($urandom);
            endk = 32 + 8 * (int'(l) + 1);
            ak = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, endk - 1));
            gk = (ak >= 0) ? ak + 1 : endk;
            bk = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, gk));
            run_txn(a, l, ak, bk, -1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_max_burst();
        test_busy_req();
        test_abort();
        test_reset_mid();
        test_addr_ext();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
